// File: rtl/rr_arb_pkg.sv
// Shared encodings and sizes for the 4-way round-robin arbiter.
package rr_arb_pkg;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam int IDX_W = 2;
  localparam int N_REQ = 4;
endpackage

// File: rtl/rr_arbiter_4_pick.sv
// Rotating-priority pick: first set request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
// Purely combinational; any=0 when no request is set (idx is then don't-care, returns ptr).
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // rot[k] is the request at position ptr+k, so the lowest set bit wins.
  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: N_REQ];
    off = 2'd0;
    if      (rot[0]) off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
    idx = ptr + off;
    any = |req;
  end
endmodule

// File: rtl/rr_arbiter_4.sv
// 4-way round-robin arbiter with hold limit; grant appears one cycle after request in IDLE.
// No backpressure: holder releases via done, dropping its request, or hold-limit timeout (then a 1-cycle gap).
module rr_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);
  localparam int CW = $clog2(MAX_HOLD);

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [CW-1:0]    cnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             expire;
  logic             req_held;

  rr_pick_4 u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign expire   = (cnt == CW'(MAX_HOLD - 1));
  assign req_held = req[gnt_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            cnt       <= '0;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (done || !req_held || expire) begin
            state     <= ST_IDLE;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
            // Only a release caused solely by the hold limit is reported.
            timeout   <= expire && !done && req_held;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
